// File: rtl/fsm_2.sv
// fsm_2: door-lock / intrusion-alarm Moore controller with optional auto-relock timer
module fsm_2 #(
  parameter int RELOCK_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic pin_correct,
  input  logic door_closed,
  input  logic intruder_detected,
  output logic lock_state,
  output logic alarm_state
);
  localparam int CW = (RELOCK_CYCLES > 0) ? $clog2(RELOCK_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CMAX = CW'(RELOCK_CYCLES);
  typedef enum logic [1:0] {UNLOCKED = 2'b00, LOCKED = 2'b01, ALARM = 2'b10} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic qual, hit;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= UNLOCKED;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  assign qual    = (RELOCK_CYCLES != 0) && state_q == UNLOCKED && door_closed && !pin_correct;
  assign cnt_inc = (cnt_q == CMAX) ? cnt_q : cnt_q + 1'b1;
  assign hit     = qual && cnt_inc == CMAX;
  always_comb begin
    state_d = UNLOCKED;
    cnt_d   = (qual && !hit) ? cnt_inc : '0;
    case (state_q)
      UNLOCKED: state_d = ((pin_correct && door_closed) || hit) ? LOCKED : UNLOCKED;
      LOCKED:   state_d = (intruder_detected || !door_closed) ? ALARM : pin_correct ? UNLOCKED : LOCKED;
      ALARM:    state_d = (pin_correct && !intruder_detected) ? UNLOCKED : ALARM;
      default:  state_d = UNLOCKED;
    endcase
  end
  assign lock_state  = state_q == LOCKED || state_q == ALARM;
  assign alarm_state = state_q == ALARM;
endmodule

// File: tb/tb_fsm_2.sv
// tb_fsm_2: directed-vector bench for fsm_2 with RELOCK_CYCLES=4 and a relock-disabled copy
module tb_fsm_2;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic pin = 1'b0, door = 1'b0, intr = 1'b0;
  logic lock, alarm, lock0, alarm0;
  int n_cmp = 0, n_bad = 0;
  fsm_2 #(.RELOCK_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .pin_correct(pin), .door_closed(door),
    .intruder_detected(intr), .lock_state(lock), .alarm_state(alarm)
  );
  fsm_2 #(.RELOCK_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .pin_correct(pin), .door_closed(door),
    .intruder_detected(intr), .lock_state(lock0), .alarm_state(alarm0)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [1:0] got, input logic [1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask
  task automatic tick(input logic p, input logic d, input logic i);
    pin = p;
    door = d;
    intr = i;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    #2 rst = 1'b0;
    #1 check("reset_async", {lock, alarm}, 2'b00);
    @(negedge clk);
    rst = 1'b1;
  endtask
  initial begin
    #12;
    check("reset", {lock, alarm}, 2'b00);
    @(negedge clk);
    rst = 1'b1;
    tick(1, 1, 0); check("t1_lock", {lock, alarm}, 2'b10);
    tick(0, 1, 0); check("t1_hold", {lock, alarm}, 2'b10);
    tick(0, 0, 0); check("t2_forced", {lock, alarm}, 2'b11);
    tick(0, 1, 0); check("t2_door_ignored", {lock, alarm}, 2'b11);
    tick(1, 1, 0); check("t2_disarm", {lock, alarm}, 2'b00);
    tick(1, 1, 0); check("t3_lock", {lock, alarm}, 2'b10);
    tick(0, 1, 1); check("t3_intr", {lock, alarm}, 2'b11);
    tick(1, 1, 1); check("t3_pin_intr", {lock, alarm}, 2'b11);
    tick(1, 1, 0); check("t3_disarm", {lock, alarm}, 2'b00);
    tick(1, 1, 0); check("prio_lock", {lock, alarm}, 2'b10);
    tick(1, 1, 1); check("prio_intr_beats_pin", {lock, alarm}, 2'b11);
    tick(1, 1, 0);
    tick(1, 1, 0); check("prio2_lock", {lock, alarm}, 2'b10);
    tick(1, 0, 0); check("prio_door_beats_pin", {lock, alarm}, 2'b11);
    tick(1, 1, 0);
    tick(1, 1, 0); check("t4_lock", {lock, alarm}, 2'b10);
    tick(0, 1, 1); check("t4_intr", {lock, alarm}, 2'b11);
    for (int k = 0; k < 3; k++) begin
      tick(0, 1, 0); check("t4_latched", {lock, alarm}, 2'b11);
    end
    do_reset();
    tick(0, 0, 1); check("t5_intr_unlocked", {lock, alarm}, 2'b00);
    tick(1, 0, 0); check("t5_open_door_pin", {lock, alarm}, 2'b00);
    for (int k = 0; k < 3; k++) begin
      tick(0, 1, 0); check("t6_closed_a", {lock, alarm}, 2'b00);
    end
    tick(0, 0, 0); check("t6_open", {lock, alarm}, 2'b00);
    for (int k = 0; k < 3; k++) begin
      tick(0, 1, 0); check("t6_closed_b", {lock, alarm}, 2'b00);
    end
    tick(0, 1, 0); check("t6_relock", {lock, alarm}, 2'b10);
    check("t6_disabled", {lock0, alarm0}, 2'b00);
    tick(1, 1, 0); check("t6_pin_unlock", {lock, alarm}, 2'b00);
    for (int k = 0; k < 3; k++) tick(0, 1, 0);
    check("relock_after_unlock_pre", {lock, alarm}, 2'b00);
    tick(0, 1, 0); check("relock_after_unlock", {lock, alarm}, 2'b10);
    tick(1, 1, 0);
    for (int k = 0; k < 3; k++) tick(0, 1, 0);
    do_reset();
    for (int k = 0; k < 3; k++) tick(0, 1, 0);
    check("cnt_reset_cleared", {lock, alarm}, 2'b00);
    tick(0, 1, 0); check("cnt_reset_relock", {lock, alarm}, 2'b10);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fsm_2.md
# fsm_2

Door-lock and intrusion-alarm controller for the smart-city home-security node. It takes three qualified sensor/keypad inputs: PIN-correct, door-closed and intruder-detected. It drives two registered status outputs: lock state and alarm state. It is a Moore state machine with an optional auto-relock timer and sits between the keypad/sensor front end and the actuator/siren drivers.

## Interface
Parameters:
- RELOCK_CYCLES, default 16: consecutive idle cycles with the door closed in UNLOCKED before the block relocks automatically. A value of 0 disables auto-relock.

Ports:
- clk  input  1  single system clock; all state changes occur on the rising edge.
- rst  input  1  reset, asynchronous and active-low. rst=0 forces the reset state immediately, independent of clk.
- pin_correct  input  1  high for the cycle(s) in which a valid PIN is presented.
- door_closed  input  1  1 = door closed, 0 = door open.
- intruder_detected  input  1  1 = intrusion sensor active.
- lock_state  output  1  1 = door locked.
- alarm_state  output  1  1 = alarm sounding.

## Operation
States (2-bit encoding):
- UNLOCKED: lock_state=0, alarm_state=0. This is the reset state.
- LOCKED: lock_state=1, alarm_state=0.
- ALARM: lock_state=1, alarm_state=1.

Transitions are evaluated at each rising clk while rst=1.

UNLOCKED:
- pin_correct=1 and door_closed=1 -> LOCKED.
- pin_correct=1 and door_closed=0 -> stay UNLOCKED. The block cannot lock an open door.
- intruder_detected is ignored in UNLOCKED; the premises are occupied and disarmed.
- Auto-relock (RELOCK_CYCLES>0):
  - relock counter increments each cycle with door_closed=1 and pin_correct=0.
  - Counter clears when door_closed=0 or the state is not UNLOCKED.
  - When the counter reaches RELOCK_CYCLES, go to LOCKED and clear the counter.

LOCKED (priority order):
1. intruder_detected=1 or door_closed=0 -> ALARM. An open door while locked is treated as forced entry.
2. pin_correct=1 -> UNLOCKED.
3. Otherwise stay LOCKED.

ALARM:
- pin_correct=1 and intruder_detected=0 -> UNLOCKED, which clears both outputs.
- pin_correct=1 and intruder_detected=1 -> stay ALARM.
- Otherwise stay ALARM; the alarm is latched.
- door_closed has no effect in ALARM.

General:
- Any unused state encoding -> UNLOCKED on the next clock.
- Relock counter width is $clog2(RELOCK_CYCLES+1), minimum 1; it saturates and never wraps.

## Timing
- Outputs are decoded from the state register only, with no combinational path from inputs. Latency from an input to an output change is one rising clk edge.
- Inputs are sampled only at the rising edge. Pulses that do not span an edge are lost, and no input synchronisers are included.
- Reset:
  - rst=0 asynchronously sets state=UNLOCKED, lock_state=0, alarm_state=0 and relock counter=0.
  - Reset mid-operation, including in ALARM, clears everything immediately.
  - The first transition occurs at the first rising edge after rst returns to 1.
- Simultaneous events:
  - In LOCKED, intruder_detected or an open door beats pin_correct.
  - In UNLOCKED, a pin_correct lock request beats the auto-relock timeout; both lead to LOCKED.
- Auto-relock fires on the RELOCK_CYCLES-th qualifying edge after entering UNLOCKED or after the door last closed.

## Test plan
1. Lock then hold:
   - Stimulus: reset (rst=0 then 1); edge with pin=1, door=1, intr=0; edge with pin=0, door=1, intr=0.
   - Required: lock=1, alarm=0 after the first edge, unchanged after the second.
2. Forced entry:
   - Stimulus: from LOCKED, edge with pin=0, door=0, intr=0.
   - Required: lock=1, alarm=1.
3. Intrusion and disarm:
   - Stimulus: from LOCKED, edge with intr=1; edge with pin=1, intr=0.
   - Required: alarm=1 after the first edge; lock=0, alarm=0 after the second.
   - Also: pin=1 with intr=1 in ALARM keeps alarm=1.
4. Latched alarm:
   - Stimulus: from LOCKED, edge with intr=1; then edges with pin=0, intr=0.
   - Required: alarm stays 1.
   - Then assert rst=0 between clock edges. Required: both outputs read 0 immediately.
5. Intruder while unlocked:
   - Stimulus: after reset, edge with pin=0, door=0, intr=1.
   - Required: lock=0, alarm=0.
   - Also: pin=1 with door=0 keeps lock=0.
6. Auto-relock with RELOCK_CYCLES=4:
   - Stimulus: in UNLOCKED with door=1 for 3 edges, then door=0 for 1 edge, then door=1 for 4 edges.
   - Required: lock=0 until the 4th closed edge, then lock=1.
